simple_out_capture: RTL
=======================

Name: simple_out_capture

Overview:
- Downstream consumer of the `simple` netlist's serial `out` pin.
- Deserialises the bit stream into WORD_W-bit words, LSB first.
- Buffers completed words in a small first-word-fall-through FIFO and presents them over a valid/ready handshake.
- Counts words lost to overflow.
- Runs on the same `iccad_clk` domain as the netlist it samples.

Parameters:
- WORD_W, 8, bits per captured word (>=2).
- FIFO_DEPTH, 4, word entries; power of two, >=2.
- CNT_W, 8, width of the overflow counter.

Ports:
- iccad_clk  input  1  clock; all state updates on its rising edge.
- iccad_rst  input  1  reset; synchronous, active-high.
- in_bit  input  1  serial data, driven directly by the netlist `out` pin.
- cap_en  input  1  sample in_bit on this edge when high.
- cap_clr  input  1  discard the partial word; FIFO contents untouched.
- word_data  output  WORD_W  FIFO head word.
- word_valid  output  1  FIFO not empty.
- word_ready  input  1  consumer accepts head when word_valid && word_ready.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of stored words.
- ovf_cnt  output  CNT_W  dropped-word count, saturating.
- ovf_sticky  output  1  set on first drop; cleared only by reset.
- busy  output  1  partial word in progress (bit count != 0).

Behaviour:
- **Reset:** one cycle of iccad_rst high returns all state to reset values on the next edge, regardless of any word in flight. A partial word or buffered words are lost.
  - Reset values: word_data=0, word_valid=0, fifo_level=0, ovf_cnt=0, ovf_sticky=0, busy=0, FSM=IDLE, bit count=0.
- **FSM:**
  - IDLE: bit count=0. Goes to SHIFT on cap_en.
  - SHIFT: word partially filled and cap_en high. Goes to HOLD when cap_en drops with bit count != 0.
  - HOLD: partial word retained, no sampling. Returns to SHIFT on cap_en.
  - Completing a word returns to IDLE with bit count=0. An immediately following cap_en re-enters SHIFT with no lost cycle.
- **Sampling:**
  - On each edge with cap_en=1, in_bit goes into shift-register bit position [bit count], and bit count increments.
  - When the WORD_W-th bit is sampled, the assembled word (including that bit) is pushed on the same edge.
  - Back-to-back cap_en yields one word every WORD_W cycles.
- **cap_clr:**
  - Zeroes bit count and the shift register on that edge; FSM goes to IDLE.
  - Has priority over cap_en: the bit presented on that edge is discarded.
  - Does not affect FIFO, ovf_cnt or ovf_sticky.
- **Latency:** if the last bit is sampled at edge N and the FIFO was empty, word_valid=1 and word_data=word from edge N onward (first-word fall-through, no extra cycle).
- **Pop:** when word_valid && word_ready at an edge, the head advances. word_data shows the next entry after that edge, or holds its last value with word_valid=0 when the FIFO becomes empty.
- **Push:**
  - Push when level<FIFO_DEPTH: stored, level+1.
  - Push and pop on the same edge: both take effect, level unchanged. This applies when full as well — the pop frees the slot, so the word is accepted.
- **Overflow:**
  - Push when full without a simultaneous pop: word dropped, FIFO unchanged, ovf_cnt+1 saturating at 2^CNT_W-1, ovf_sticky=1.
  - Sampling continues regardless of FIFO state; overflow never stalls the capture path.
- **Pointers:** read/write pointers wrap modulo FIFO_DEPTH. Level is tracked separately so full and empty are unambiguous.
- **Undefined input:** word_ready while word_valid=0 has no effect.
- **Outputs:** all outputs are registered, or driven from registered state without input-to-output combinational paths, except word_data mux on the read pointer.

Test Plan:
- **Basic capture, FIFO empty:** reset; cap_en=1 for 8 cycles with in_bit=1,0,1,1,0,0,1,0 -> word_valid rises after the 8th edge, word_data=0x4D, fifo_level=1, busy=0.
- **HOLD across a gap:** send 3 bits, drop cap_en for 5 cycles, then send the remaining 5 bits -> busy=1 during the gap, single word 0x4D, no spurious push.
- **Overflow:** word_ready=0; stream 5 words 0x01..0x05 -> fifo_level=4, ovf_cnt=1, ovf_sticky=1. Then pop 4 -> 0x01,0x02,0x03,0x04 in order, word_valid=0.
- **Full with same-edge pop:** fill to 4, hold word_ready=1 on the edge the 5th word completes -> level stays 4, ovf_cnt=0, pop order 0x01..0x05 intact.
- **cap_clr mid-word:** send 4 bits, assert cap_clr together with cap_en -> busy=0, that bit discarded; next 8 bits 0xFF -> word_data=0xFF. The 8-bit ovf_cnt saturates at 255 after 300 forced drops.
- **Reset mid-operation:** with 2 words stored and 5 bits pending, assert iccad_rst for 1 cycle -> next edge: level=0, word_valid=0, busy=0, ovf_cnt=0. Next full word is captured correctly.

Source files
------------

// File: rtl/simple_out_capture.sv
// Serial-to-parallel capture of the netlist `out` pin: LSB-first word assembly,
// a first-word-fall-through FIFO with valid/ready read side, and overflow accounting.
module simple_out_capture #(
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                          iccad_clk,
  input  logic                          iccad_rst,
  input  logic                          in_bit,
  input  logic                          cap_en,
  input  logic                          cap_clr,
  output logic [WORD_W-1:0]             word_data,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              ovf_cnt,
  output logic                          ovf_sticky,
  output logic                          busy
);

  localparam int BIT_W = $clog2(WORD_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t              state, state_next;
  logic [BIT_W-1:0]    bit_cnt;
  logic [WORD_W-1:0]   shreg;
  logic [WORD_W-1:0]   asm_word;
  logic [WORD_W-1:0]   mem [FIFO_DEPTH];
  logic [WORD_W-1:0]   last_word;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic                sample, push, pop, full, accept, drop;

  // cap_clr wins over cap_en: the bit on a clearing edge is never sampled.
  assign sample = cap_en && !cap_clr;
  assign push   = sample && (bit_cnt == LAST_BIT);
  assign pop    = word_valid && word_ready;
  assign full   = (fifo_level == FULL_LVL);
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  // Word as it will look once the bit on this edge lands, so it can be pushed same-edge.
  always_comb begin
    // NOTE: every variable written in a combinational block gets a default first, otherwise synthesis infers a latch.
    asm_word          = shreg;
    asm_word[bit_cnt] = in_bit;
  end

  // FSM: state register
  always_ff @(posedge iccad_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (iccad_rst) state <= IDLE;
    else           state <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state;
    if (cap_clr)          state_next = IDLE;
    else if (cap_en)      state_next = (bit_cnt == LAST_BIT) ? IDLE : SHIFT;
    else if (bit_cnt != '0) state_next = HOLD;
    else                  state_next = IDLE;
  end

  // FSM: outputs
  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge iccad_clk) begin
    if (iccad_rst || cap_clr) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (sample) begin
      if (bit_cnt == LAST_BIT) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= asm_word;
      end
    end
  end

  // NOTE: the storage array carries no reset; pointers and level define which entries are meaningful.
  always_ff @(posedge iccad_clk) begin
    if (accept) mem[wr_ptr] <= asm_word;
  end

  always_ff @(posedge iccad_clk) begin
    if (iccad_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      last_word  <= '0;
      ovf_cnt    <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_word <= mem[rd_ptr];
      end
      case ({accept, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (drop) begin
        ovf_sticky <= 1'b1;
        if (ovf_cnt != {CNT_W{1'b1}}) ovf_cnt <= ovf_cnt + 1'b1;
      end
    end
  end

  assign word_valid = (fifo_level != '0);
  // When empty, the last popped word stays visible instead of a stale array slot.
  assign word_data  = word_valid ? mem[rd_ptr] : last_word;

endmodule
